pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; successor to the single-register PC latch.
- Each cycle it selects the next fetch PC from five sources: trap vector, execute-stage redirect, return-address-stack (RAS) pop, decode-stage predicted target, or the sequential increment.
- It holds a circular RAS for call/return prediction.
- It flags misaligned targets and provides a post-reset boot cycle before the first valid PC.

Parameters:
- ADDR_WIDTH, 64, width of all PC and target buses.
- RESET_ADDR, 0, PC value loaded at reset.
- INSTR_BYTES, 4, sequential increment and alignment granule; power of 2, at least 2.
- RAS_DEPTH, 4, number of RAS entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- stall  in  1  hold PC and RAS; trap and redirect override it.
- trap_valid  in  1  take trap vector.
- trap_target  in  ADDR_WIDTH  trap vector address.
- redirect_valid  in  1  mispredict or flush redirect from execute.
- redirect_target  in  ADDR_WIDTH  corrected fetch address.
- pred_taken  in  1  decode predictor says taken.
- pred_target  in  ADDR_WIDTH  predicted target.
- call  in  1  instruction at pc_reg is a call; push return address.
- ret  in  1  instruction at pc_reg is a return; pop RAS for target.
- pc_reg  out  ADDR_WIDTH  current fetch PC.
- pc_valid  out  1  pc_reg is a legal fetch address.
- misaligned  out  1  one-cycle pulse: last accepted target had nonzero low bits.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count equals RAS_DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_reg=RESET_ADDR, pc_valid=0, misaligned=0.
  - RAS count=0, top pointer=0; ras_empty=1, ras_full=0.
  - RAS entry contents are don't-care.
- Boot cycle:
  - The first rising edge with reset=1 only sets pc_valid=1; pc_reg stays RESET_ADDR.
  - All inputs are ignored on this edge, including trap and redirect.
  - pc_valid then stays 1 until the next reset.
- Next-PC priority when pc_valid=1 (evaluated each edge, highest first):
  1. trap_valid: target=trap_target. Applies even when stall=1.
  2. redirect_valid: target=redirect_target. Applies even when stall=1.
  3. stall=1: pc_reg, RAS and pointers hold; misaligned=0.
  4. ret=1 and RAS not empty: target=RAS[top]; pop.
  5. pred_taken=1: target=pred_target.
  6. Otherwise: pc_reg + INSTR_BYTES, modulo 2^ADDR_WIDTH (wraps silently, no flag).
- A trap or redirect discards that cycle's call, ret and pred_taken; the RAS is not modified.
- ret with RAS empty: no pop; falls through to priority 5/6; no error output.
- Alignment:
  - Any selected non-sequential target has its low log2(INSTR_BYTES) bits cleared before loading pc_reg.
  - misaligned=1 for exactly the cycle after the edge that accepted a target whose low bits were nonzero; 0 otherwise.
- RAS push (call=1, priority 4-6 path):
  - Pushed value is pc_reg + INSTR_BYTES (wrapped).
  - Pointer advances modulo RAS_DEPTH; count increments and saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry.
- call and ret together:
  - If the RAS is not empty, the pop is performed first (target = old top), then the push writes the new return address into the same slot.
  - Net count is unchanged.
  - If the RAS is empty, the call pushes and count becomes 1.
- ras_empty and ras_full are registered, combinational from count, and valid the cycle after the update.
- Latency: one cycle from input sample to pc_reg update. No combinational path from any input to any output.

Test Plan:
1. Assert reset=0 mid-run with pc_reg=0x1000, then release → immediate pc_reg=RESET_ADDR, pc_valid=0; first edge gives pc_valid=1, pc_reg=0; next edge gives pc_reg=4.
2. Sequential run from 0xFFFF_FFFF_FFFF_FFF8 for 3 cycles → pc_reg = …FFFC, 0x0, 0x4; misaligned stays 0.
3. stall=1 with redirect_valid=1, redirect_target=0x2002 in the same cycle → pc_reg=0x2000; misaligned=1 for one cycle; a following stall-only cycle holds 0x2000.
4. trap_valid, redirect_valid, pred_taken and ret all asserted in one cycle, trap_target=0x80 → pc_reg=0x80; RAS count unchanged.
5. Five calls at pc 0x100, 0x200, 0x300, 0x400, 0x500 with RAS_DEPTH=4, then five rets → targets 0x504, 0x404, 0x304, 0x204; fifth ret sees ras_empty=1 and falls to sequential; ras_full=1 after the 4th call.
6. call+ret together with the RAS holding 0x104 and pc_reg=0x300 → pc_reg=0x104; new top=0x304; count unchanged.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: five-way next-PC select with a circular
// return-address stack, target alignment check and a post-reset boot cycle.
module pc_gen #(
  parameter int unsigned              ADDR_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0]    RESET_ADDR  = '0,
  parameter int unsigned              INSTR_BYTES = 4,
  parameter int unsigned              RAS_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  trap_valid,
  input  logic [ADDR_WIDTH-1:0] trap_target,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  pred_taken,
  input  logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  call,
  input  logic                  ret,
  output logic [ADDR_WIDTH-1:0] pc_reg,
  output logic                  pc_valid,
  output logic                  misaligned,
  output logic                  ras_empty,
  output logic                  ras_full
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_WIDTH-1:0] Incr      = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~(Incr - ADDR_WIDTH'(1));
  localparam logic [CntW-1:0]       CntMax    = CntW'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic [PtrW-1:0]       top_q, top_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

  logic                  ras_we;
  logic [PtrW-1:0]       ras_wptr;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] tgt;
  logic                  take_tgt;
  logic                  pop;

  assign seq_pc = pc_q + Incr;

  always_comb begin
    pc_d         = pc_q;
    pc_valid_d   = 1'b1;
    misaligned_d = 1'b0;
    top_d        = top_q;
    cnt_d        = cnt_q;
    ras_we       = 1'b0;
    ras_wptr     = top_q;
    tgt          = '0;
    take_tgt     = 1'b0;
    pop          = 1'b0;

    if (!pc_valid_q) begin
      // Boot edge: only pc_valid rises, every other input is ignored.
    end else if (trap_valid) begin
      tgt      = trap_target;
      take_tgt = 1'b1;
    end else if (redirect_valid) begin
      tgt      = redirect_target;
      take_tgt = 1'b1;
    end else if (stall) begin
      // Hold everything.
    end else begin
      pop = ret && (cnt_q != '0);
      if (pop) begin
        tgt      = ras_q[top_q];
        take_tgt = 1'b1;
      end else if (pred_taken) begin
        tgt      = pred_target;
        take_tgt = 1'b1;
      end else begin
        pc_d = seq_pc;
      end

      if (call) begin
        ras_we = 1'b1;
        // With a simultaneous pop the new return address reuses the popped slot.
        if (!pop) begin
          ras_wptr = top_q + PtrW'(1);
          top_d    = top_q + PtrW'(1);
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        end
      end else if (pop) begin
        top_d = top_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end

    if (take_tgt) begin
      pc_d         = tgt & AlignMask;
      misaligned_d = |(tgt & ~AlignMask);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_ADDR;
      pc_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      top_q        <= '0;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      misaligned_q <= misaligned_d;
      top_q        <= top_d;
      cnt_q        <= cnt_d;
    end
  end

  // Entry contents are don't-care after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_wptr] <= seq_pc;
  end

  assign pc_reg     = pc_q;
  assign pc_valid   = pc_valid_q;
  assign misaligned = misaligned_q;
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = (cnt_q == CntMax);

endmodule
